bus_intercon_rr: RTL and testbench

Parametrised multi-master, multi-slave bus interconnect for the jpu system bus. It arbitrates round-robin among NUM_MASTERS request ports and decodes each granted address against NUM_SLAVES parametrised windows. It forwards one transaction at a time to the selected slave and returns read data, write completion or an error to the granting master. It extends the single-master, fixed-latency interconnect with multiple masters, variable-latency slaves (ack handshake) and a timeout error path.

---
 rtl/bus_intercon_rr.sv | 154 +++++++++++++++
 tb/tb_bus_intercon_rr.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_intercon_rr.sv
// Round-robin multi-master / multi-slave interconnect for the jpu system bus.
// One transaction in flight at a time; variable-latency slaves with ack and a timeout error path.
module bus_intercon_rr #(
    parameter int                        NUM_MASTERS  = 2,
    parameter int                        NUM_SLAVES   = 2,
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE   = {32'habcd0000, 32'h12340000},
    parameter logic [NUM_SLAVES*6-1:0]   SLAVE_AWIDTH = {6'd6, 6'd5},
    parameter int                        TIMEOUT      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS-1:0]      m_en_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*32-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*32-1:0]   m_data_i,
    input  logic [NUM_MASTERS*4-1:0]    m_byte_mask_i,
    output logic [31:0]                 m_data_o,
    output logic [NUM_MASTERS-1:0]      m_valid_o,
    output logic [NUM_MASTERS-1:0]      m_stall_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_SLAVES-1:0]       s_sel_o,
    output logic                        s_we_o,
    output logic [31:0]                 s_addr_o,
    output logic [31:0]                 s_data_o,
    output logic [3:0]                  s_byte_mask_o,
    input  logic [NUM_SLAVES*32-1:0]    s_data_i,
    input  logic [NUM_SLAVES-1:0]       s_ack_i
);

    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t          state_reg, state_next;
    logic [MW-1:0]   last_grant_reg, last_grant_next;
    logic [MW-1:0]   owner_reg, owner_next;
    logic [SW-1:0]   slave_reg, slave_next;
    logic [TW-1:0]   timer_reg, timer_next;

    logic [MW-1:0]          grant;
    logic                   found;
    logic [NUM_SLAVES-1:0]  hit;
    logic [SW-1:0]          hit_idx;
    logic                   hit_any;
    logic [31:0]            req_addr;
    logic                   ack_hit, timeout, slot, issue, legal;

    assign req_addr      = m_addr_i[int'(grant)*32 +: 32];
    assign s_we_o        = m_we_i[grant];
    assign s_addr_o      = req_addr;
    assign s_data_o      = m_data_i[int'(grant)*32 +: 32];
    assign s_byte_mask_o = m_byte_mask_i[int'(grant)*4 +: 4];

    // Window compare on the bits above the window size; base low bits are don't-care.
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
        localparam int          AW   = int'(SLAVE_AWIDTH[6*gi +: 6]);
        localparam logic [31:0] BASE = SLAVE_BASE[32*gi +: 32];
        assign hit[gi] = (req_addr >> (AW + 2)) == (BASE >> (AW + 2));
    end

    always_comb begin
        hit_idx = '0;
        hit_any = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = SW'(i);
                hit_any = 1'b1;
            end
        end
    end

    // Walk downwards so the nearest requester after last_grant is assigned last.
    always_comb begin
        grant = last_grant_reg;
        found = 1'b0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (m_en_i[MW'((int'(last_grant_reg) + k) % NUM_MASTERS)]) begin
                grant = MW'((int'(last_grant_reg) + k) % NUM_MASTERS);
                found = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_stall
        assign m_stall_o[gi] = m_en_i[gi] & ~(issue && (grant == MW'(gi)));
    end

    always_comb begin
        ack_hit = (state_reg == WAIT) && s_ack_i[slave_reg];
        timeout = (state_reg == WAIT) && !ack_hit && (timer_reg == TW'(TIMEOUT - 1));
        slot    = !rst && ((state_reg != WAIT) || ack_hit);
        issue   = slot && found;
        legal   = hit_any && (req_addr[1:0] == 2'b00);

        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        owner_next      = owner_reg;
        slave_next      = slave_reg;
        timer_next      = timer_reg;

        if (issue) begin
            last_grant_next = grant;
            owner_next      = grant;
            if (legal) begin
                state_next = WAIT;
                slave_next = hit_idx;
                timer_next = '0;
            end else begin
                state_next = ERR;
            end
        end else begin
            case (state_reg)
                ERR:     state_next = IDLE;
                WAIT: begin
                    if (ack_hit || timeout) state_next = IDLE;
                    else                    timer_next = timer_reg + 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        s_sel_o   = '0;
        m_valid_o = '0;
        m_err_o   = '0;
        m_data_o  = '0;
        if (issue && legal) s_sel_o[hit_idx] = 1'b1;
        if (ack_hit) begin
            m_valid_o[owner_reg] = 1'b1;
            m_data_o             = s_data_i[int'(slave_reg)*32 +: 32];
        end
        if ((state_reg == ERR) || timeout) m_err_o[owner_reg] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= MW'(NUM_MASTERS - 1);
            owner_reg      <= '0;
            slave_reg      <= '0;
            timer_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            owner_reg      <= owner_next;
            slave_reg      <= slave_next;
            timer_reg      <= timer_next;
        end
    end

endmodule

// File: tb/tb_bus_intercon_rr.sv
// Bench for bus_intercon_rr: directed scenarios then random traffic, checked each cycle
// against a transaction-level model of the interconnect.
module tb_bus_intercon_rr;

    localparam int NM = 2;
    localparam int NS = 2;
    localparam int TO = 16;
    localparam logic [NS*32-1:0] BASE = {32'habcd0000, 32'h12340000};
    localparam logic [NS*6-1:0]  AWID = {6'd6, 6'd5};

    logic                clk = 1'b0;
    logic                rst;
    logic [NM-1:0]       m_en, m_we;
    logic [NM*32-1:0]    m_addr, m_wdata;
    logic [NM*4-1:0]     m_mask;
    logic [31:0]         m_rdata;
    logic [NM-1:0]       m_valid, m_stall, m_err;
    logic [NS-1:0]       s_sel;
    logic                s_we;
    logic [31:0]         s_addr, s_wdata;
    logic [3:0]          s_mask;
    logic [NS*32-1:0]    s_rdata;
    logic [NS-1:0]       s_ack;

    bit          r_en [NM];
    bit          r_we [NM];
    logic [31:0] r_addr [NM];
    logic [31:0] r_data [NM];
    logic [3:0]  r_mask [NM];
    bit          r_ack [NS];
    logic [31:0] r_sdata [NS];

    for (genvar gi = 0; gi < NM; gi++) begin : g_mdrv
        assign m_en[gi]            = r_en[gi];
        assign m_we[gi]            = r_we[gi];
        assign m_addr[32*gi +: 32] = r_addr[gi];
        assign m_wdata[32*gi +: 32] = r_data[gi];
        assign m_mask[4*gi +: 4]   = r_mask[gi];
    end
    for (genvar gi = 0; gi < NS; gi++) begin : g_sdrv
        assign s_ack[gi]            = r_ack[gi];
        assign s_rdata[32*gi +: 32] = r_sdata[gi];
    end

    bus_intercon_rr #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_BASE(BASE),
        .SLAVE_AWIDTH(AWID), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_en_i(m_en), .m_we_i(m_we), .m_addr_i(m_addr), .m_data_i(m_wdata),
        .m_byte_mask_i(m_mask), .m_data_o(m_rdata), .m_valid_o(m_valid),
        .m_stall_o(m_stall), .m_err_o(m_err), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_addr_o(s_addr), .s_data_o(s_wdata), .s_byte_mask_o(s_mask),
        .s_data_i(s_rdata), .s_ack_i(s_ack)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int err_cnt = 0;
    int last_err_cyc = -1;

    // Slave environment: word memories, ack latency (0 = never acks), one-shot injected acks.
    logic [31:0] smem [NS][64];
    int          lat [NS];
    int          cnt [NS];
    bit          inject [NS];
    logic [31:0] rd_latch [NS];

    // Reference model: at most one outstanding transaction plus a pending error response.
    bit          busy, errp, rd;
    int          own, sl, waited, ptr, issued;
    logic [31:0] rdval;
    logic [31:0] shadow [NS][64];
    logic [31:0] valid_data_q [$];
    int          valid_owner_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        logic [63:0] size, lo, a64;
        a64 = {32'd0, a};
        for (int i = 0; i < NS; i++) begin
            size = 64'd1 << (int'(AWID[6*i +: 6]) + 2);
            lo   = {32'd0, BASE[32*i +: 32]} & ~(size - 64'd1);
            if (a64 >= lo && a64 < lo + size) return i;
        end
        return -1;
    endfunction

    function automatic int widx(input int s, input logic [31:0] a);
        return int'(a[31:2]) & ((1 << int'(AWID[6*s +: 6])) - 1);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] mk);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (mk[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic env_tick();
        for (int s = 0; s < NS; s++) begin
            bit ak;
            ak = 1'b0;
            if (cnt[s] > 0) begin
                cnt[s]--;
                if (cnt[s] == 0) ak = 1'b1;
            end
            if (inject[s]) begin
                ak = 1'b1;
                inject[s] = 1'b0;
            end
            r_ack[s]   = ak;
            r_sdata[s] = ak ? rd_latch[s] : $urandom;
        end
    endtask

    task automatic eval();
        logic [NM-1:0] e_valid, e_err, e_stall;
        logic [NS-1:0] e_sel;
        logic [31:0]   e_data, a;
        bit            ack_now, to_now, legal;
        int            g, h, w;
        #1;
        if (rst) begin
            busy = 0; errp = 0; own = 0; ptr = NM - 1; waited = 0;
            for (int s = 0; s < NS; s++) cnt[s] = 0;
        end
        e_valid = '0; e_err = '0; e_sel = '0; e_data = '0; e_stall = m_en;
        g = -1; h = -1; legal = 0; a = '0;
        ack_now = busy && r_ack[sl];
        to_now  = busy && !ack_now && (waited == TO - 1);
        if (ack_now) begin
            e_valid = e_valid | NM'(1 << own);
            e_data  = rd ? rdval : r_sdata[sl];
        end
        if (errp || to_now) e_err = e_err | NM'(1 << own);
        if (!rst && (!busy || ack_now))
            for (int k = 1; k <= NM; k++)
                if (g < 0 && r_en[(ptr + k) % NM]) g = (ptr + k) % NM;
        if (g >= 0) begin
            e_stall = e_stall & ~NM'(1 << g);
            a = r_addr[g];
            h = decode(a);
            legal = (h >= 0) && (a[1:0] == 2'b00);
            if (legal) e_sel = NS'(1 << h);
        end
        chk("s_sel", 64'(s_sel), 64'(e_sel));
        chk("m_valid", 64'(m_valid), 64'(e_valid));
        chk("m_err", 64'(m_err), 64'(e_err));
        chk("m_stall", 64'(m_stall), 64'(e_stall));
        chk("m_data", 64'(m_rdata), 64'(e_data));
        if (legal) begin
            chk("s_addr", 64'(s_addr), 64'(a));
            chk("s_we", 64'(s_we), 64'(r_we[g]));
            chk("s_wdata", 64'(s_wdata), 64'(r_data[g]));
            chk("s_mask", 64'(s_mask), 64'(r_mask[g]));
        end
        if (m_valid != '0) begin
            valid_data_q.push_back(m_rdata);
            valid_owner_q.push_back(m_valid[1] ? 1 : 0);
        end
        if (m_err != '0) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        for (int s = 0; s < NS; s++) begin
            if (((s_sel >> s) & 1) != 0) begin
                w = widx(s, s_addr);
                if (s_we) smem[s][w] = merge(smem[s][w], s_wdata, s_mask);
                rd_latch[s] = smem[s][w];
                cnt[s] = lat[s];
            end
        end
        errp = 0;
        if (ack_now || to_now) busy = 0;
        else if (busy) waited++;
        if (g >= 0) begin
            ptr = g;
            own = g;
            if (legal) begin
                busy = 1; sl = h; waited = 0; rd = !r_we[g];
                w = widx(h, a);
                if (r_we[g]) shadow[h][w] = merge(shadow[h][w], r_data[g], r_mask[g]);
                rdval = shadow[h][w];
            end else begin
                errp = 1;
            end
        end
        issued = g;
    endtask

    task automatic step();
        eval();
        @(posedge clk);
        #1;
        cyc++;
        env_tick();
    endtask

    task automatic req(input int m, input logic [31:0] a, input logic [31:0] d,
                       input bit we, input logic [3:0] mk);
        r_en[m] = 1; r_addr[m] = a; r_data[m] = d; r_we[m] = we; r_mask[m] = mk;
    endtask

    task automatic rand_req(input int m);
        int kind;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        if (kind == 0)      a = 32'h12340001 + 32'($urandom_range(0, 30));
        else if (kind == 1) a = 32'h00001000;
        else if (kind < 6)  a = 32'h12340000 + 32'(4 * $urandom_range(0, 31));
        else                a = 32'habcd0000 + 32'(4 * $urandom_range(0, 63));
        req(m, a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, nv, ne;
        rst = 1'b1;
        for (int m = 0; m < NM; m++) req(m, 32'h0, 32'h0, 0, 4'h0);
        for (int m = 0; m < NM; m++) r_en[m] = 0;
        for (int s = 0; s < NS; s++) begin
            lat[s] = 1; cnt[s] = 0; inject[s] = 0; rd_latch[s] = '0;
            r_ack[s] = 0; r_sdata[s] = '0;
            for (int w = 0; w < 64; w++) begin
                smem[s][w]   = $urandom;
                shadow[s][w] = smem[s][w];
            end
        end
        busy = 0; errp = 0; rd = 0; own = 0; sl = 0; waited = 0; ptr = NM - 1; issued = -1;
        rdval = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state: no strobes or responses, stall mirrors requests.
        r_en[0] = 1; r_en[1] = 1;
        eval();
        r_en[0] = 0; r_en[1] = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        env_tick();

        // Single master to the ram window, full and masked writes, then read back.
        valid_data_q.delete();
        req(0, 32'h12340000, 32'hdeadbeef, 1, 4'hf); step();
        req(0, 32'h12340004, 32'h12345678, 1, 4'hf); step();
        req(0, 32'h12340004, 32'haa000000, 1, 4'b1000); step();
        req(0, 32'h12340004, 32'h000000bb, 1, 4'b0001); step();
        req(0, 32'h12340000, 32'h0, 0, 4'hf); step();
        req(0, 32'h12340004, 32'h0, 0, 4'hf); step();
        r_en[0] = 0; step(); step();
        chk("t1_nvalid", 64'(valid_data_q.size()), 64'd6);
        chk("t1_rd0", 64'(valid_data_q[4]), 64'h00000000deadbeef);
        chk("t1_rd1", 64'(valid_data_q[5]), 64'h00000000aa3456bb);

        // Both masters streaming to different slaves; m0 granted last, so m1 leads.
        valid_owner_q.delete();
        req(0, 32'h12340008, 32'h0, 0, 4'hf);
        req(1, 32'habcd0010, 32'h0, 0, 4'hf);
        repeat (8) step();
        r_en[0] = 0; r_en[1] = 0; step(); step();
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_owner%0d", i), 64'(valid_owner_q[i]), 64'((i + 1) % 2));

        // Unaligned and unmapped addresses.
        ne = err_cnt;
        req(0, 32'h12340001, 32'h0, 0, 4'hf); step();
        req(0, 32'h00000000, 32'h0, 0, 4'hf); step();
        r_en[0] = 0; step(); step();
        chk("t3_errs", 64'(err_cnt - ne), 64'd2);

        // Three-cycle slave: the other master waits for the ack cycle.
        lat[1] = 3;
        valid_owner_q.delete();
        req(0, 32'habcd0020, 32'h0, 0, 4'hf); step();
        r_en[0] = 0;
        req(1, 32'h12340010, 32'h5a5a5a5a, 1, 4'hf);
        repeat (5) begin
            step();
            if (issued == 1) r_en[1] = 0;
        end
        r_en[1] = 0; step();
        chk("t4_nvalid", 64'(valid_owner_q.size()), 64'd2);
        lat[1] = 1;

        // Silent slave: timeout error, then a late ack that must be ignored.
        lat[0] = 0;
        nv = valid_data_q.size();
        t0 = cyc;
        req(0, 32'h12340000, 32'h0, 0, 4'hf); step();
        r_en[0] = 0;
        for (int c = 1; c <= 22; c++) begin
            if (c == 19) inject[0] = 1;
            step();
        end
        chk("t5_err_cyc", 64'(last_err_cyc - t0), 64'(TO));
        chk("t5_no_valid", 64'(valid_data_q.size() - nv), 64'd0);
        lat[0] = 1;

        // Reset during an outstanding transaction; master 0 has priority afterwards.
        lat[1] = 3;
        req(1, 32'habcd0000, 32'h0, 0, 4'hf); step();
        r_en[1] = 0; step();
        rst = 1'b1;
        req(0, 32'h12340000, 32'h0, 0, 4'hf);
        req(1, 32'habcd0004, 32'h0, 0, 4'hf);
        step();
        rst = 1'b0;
        valid_owner_q.delete();
        repeat (2) begin
            step();
            if (issued >= 0) r_en[issued] = 0;
        end
        r_en[0] = 0; r_en[1] = 0;
        repeat (5) step();
        chk("t6_prio", 64'(valid_owner_q[0]), 64'd0);
        lat[1] = 1;

        // Random traffic with varying slave latency.
        for (int c = 0; c < 400; c++) begin
            if (c % 100 == 0) for (int s = 0; s < NS; s++) lat[s] = $urandom_range(1, 4);
            for (int m = 0; m < NM; m++)
                if (!r_en[m] && $urandom_range(0, 3) != 0) rand_req(m);
            step();
            if (issued >= 0) r_en[issued] = 0;
        end
        r_en[0] = 0; r_en[1] = 0;
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
